// File: rtl/peripheral_bus_if.sv
// rtl/peripheral_bus_if.sv - CPU load/store bus shared by data memory and peripheral_bus
interface peripheral_bus_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] Read_data;

    modport master (
        output MemRead, MemWrite, Address, Write_data,
        input  Read_data
    );

    modport slave (
        input  MemRead, MemWrite, Address, Write_data,
        output Read_data
    );
endinterface

// File: rtl/peripheral_bus.sv
// rtl/peripheral_bus.sv - memory-mapped timer, GPIO, 7-segment and UART transmitter
module peripheral_bus #(
    parameter int BAUD_DIV = 5208
) (
    input  logic               clk,
    input  logic               reset,
    peripheral_bus_if.slave    bus,
    input  logic [7:0]         switch,
    output logic [7:0]         led,
    output logic [11:0]        digi,
    output logic               irqout,
    output logic               uart_txd
);

    localparam logic [31:0] ADDR_TH   = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL   = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON = 32'h4000_0008;
    localparam logic [31:0] ADDR_LED  = 32'h4000_000C;
    localparam logic [31:0] ADDR_SW   = 32'h4000_0010;
    localparam logic [31:0] ADDR_DIGI = 32'h4000_0014;
    localparam logic [31:0] ADDR_TXD  = 32'h4000_0018;
    localparam logic [31:0] ADDR_CON  = 32'h4000_001C;

    localparam int              CW        = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0]   BAUD_LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_t;

    logic [31:0]  r_th;
    logic [31:0]  r_tl;
    logic [2:0]   r_tcon;
    logic [7:0]   r_led;
    logic [11:0]  r_digi;

    uart_state_t  r_state;
    logic [7:0]   r_shift;
    logic [2:0]   r_bit_idx;
    logic [CW-1:0] r_baud_cnt;
    logic         r_txd;
    logic         r_busy;

    uart_state_t  w_state_nxt;
    logic [7:0]   w_shift_nxt;
    logic [2:0]   w_bit_idx_nxt;
    logic [CW-1:0] w_baud_cnt_nxt;
    logic         w_txd_nxt;
    logic         w_busy_nxt;
    logic         w_bit_end;

    logic         w_wr_th;
    logic         w_wr_tl;
    logic         w_wr_tcon;
    logic         w_wr_led;
    logic         w_wr_digi;
    logic         w_wr_txd;
    logic         w_overflow;
    logic         w_irq_event;
    logic [31:0]  w_rdata;

    assign w_wr_th   = bus.MemWrite && (bus.Address == ADDR_TH);
    assign w_wr_tl   = bus.MemWrite && (bus.Address == ADDR_TL);
    assign w_wr_tcon = bus.MemWrite && (bus.Address == ADDR_TCON);
    assign w_wr_led  = bus.MemWrite && (bus.Address == ADDR_LED);
    assign w_wr_digi = bus.MemWrite && (bus.Address == ADDR_DIGI);
    assign w_wr_txd  = bus.MemWrite && (bus.Address == ADDR_TXD);

    assign w_overflow  = r_tcon[0] && (r_tl == 32'hFFFF_FFFF);
    assign w_irq_event = w_overflow && r_tcon[1];

    // CPU writes win over counting; the overflow status bit is ORed in so an irq is never lost
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_th   <= '0;
            r_tl   <= '0;
            r_tcon <= '0;
        end else begin
            if (w_wr_th) begin
                r_th <= bus.Write_data;
            end
            if (w_wr_tl) begin
                r_tl <= bus.Write_data;
            end else if (r_tcon[0]) begin
                r_tl <= w_overflow ? r_th : r_tl + 32'd1;
            end
            if (w_wr_tcon) begin
                r_tcon <= {bus.Write_data[2] | w_irq_event, bus.Write_data[1:0]};
            end else if (w_irq_event) begin
                r_tcon[2] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led  <= '0;
            r_digi <= '0;
        end else begin
            if (w_wr_led) begin
                r_led <= bus.Write_data[7:0];
            end
            if (w_wr_digi) begin
                r_digi <= bus.Write_data[11:0];
            end
        end
    end

    assign w_bit_end = (r_baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_baud_cnt <= '0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_txd      <= w_txd_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // The shift register moves right at each data bit boundary, so bit 1 is the next bit out
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_idx_nxt  = r_bit_idx;
        w_baud_cnt_nxt = r_baud_cnt;
        w_txd_nxt      = r_txd;
        w_busy_nxt     = r_busy;
        case (r_state)
            S_IDLE: begin
                if (w_wr_txd) begin
                    w_state_nxt    = S_START;
                    w_shift_nxt    = bus.Write_data[7:0];
                    w_bit_idx_nxt  = '0;
                    w_baud_cnt_nxt = '0;
                    w_txd_nxt      = 1'b0;
                    w_busy_nxt     = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_baud_cnt_nxt = '0;
                    w_state_nxt    = S_DATA;
                    w_txd_nxt      = r_shift[0];
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_txd_nxt   = 1'b1;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_txd_nxt     = r_shift[1];
                    end
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_cnt_nxt = '0;
                    w_state_nxt    = S_IDLE;
                    w_txd_nxt      = 1'b1;
                    w_busy_nxt     = 1'b0;
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_baud_cnt_nxt = '0;
                w_txd_nxt      = 1'b1;
                w_busy_nxt     = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_rdata = '0;
        if (bus.MemRead) begin
            case (bus.Address)
                ADDR_TH:   w_rdata = r_th;
                ADDR_TL:   w_rdata = r_tl;
                ADDR_TCON: w_rdata = {29'd0, r_tcon};
                ADDR_LED:  w_rdata = {24'd0, r_led};
                ADDR_SW:   w_rdata = {24'd0, switch};
                ADDR_DIGI: w_rdata = {20'd0, r_digi};
                ADDR_CON:  w_rdata = {31'd0, r_busy};
                default:   w_rdata = '0;
            endcase
        end
    end

    assign bus.Read_data = w_rdata;
    assign led           = r_led;
    assign digi          = r_digi;
    assign irqout        = r_tcon[1] & r_tcon[2];
    assign uart_txd      = r_txd;

endmodule

// File: tb/tb_peripheral_bus.sv
// tb/tb_peripheral_bus.sv - scoreboard bench for peripheral_bus
module tb_peripheral_bus;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_SW   = 32'h4000_0010;
    localparam logic [31:0] A_DIGI = 32'h4000_0014;
    localparam logic [31:0] A_TXD  = 32'h4000_0018;
    localparam logic [31:0] A_CON  = 32'h4000_001C;

    localparam int K_RD   = 0;
    localparam int K_LED  = 1;
    localparam int K_DIGI = 2;
    localparam int K_IRQ  = 3;
    localparam int K_TXD  = 4;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } sb_entry_t;

    logic        clk;
    logic        reset;
    logic [7:0]  switch;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irqout;
    logic        uart_txd;

    sb_entry_t   sb_q[$];
    sb_entry_t   mon_e;
    logic [31:0] mon_act;
    int          n_checks;
    int          n_errors;

    peripheral_bus_if bus();

    peripheral_bus #(.BAUD_DIV(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .switch   (switch),
        .led      (led),
        .digi     (digi),
        .irqout   (irqout),
        .uart_txd (uart_txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every expectation queued during a cycle is compared at that cycle's falling edge
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            case (mon_e.kind)
                K_RD:    mon_act = bus.Read_data;
                K_LED:   mon_act = {24'd0, led};
                K_DIGI:  mon_act = {20'd0, digi};
                K_IRQ:   mon_act = {31'd0, irqout};
                default: mon_act = {31'd0, uart_txd};
            endcase
            n_checks++;
            if (mon_act !== mon_e.exp) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int kind, input logic [31:0] exp, input string name);
        sb_entry_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.MemWrite   = 1'b1;
        bus.Address    = addr;
        bus.Write_data = data;
        tick();
        bus.MemWrite   = 1'b0;
        bus.Address    = '0;
        bus.Write_data = '0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        bus.MemRead = 1'b1;
        bus.Address = addr;
        chk(K_RD, exp, name);
        tick();
        bus.MemRead = 1'b0;
        bus.Address = '0;
    endtask

    initial begin
        logic [9:0] frame;
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b1;
        switch         = 8'h00;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.Address    = '0;
        bus.Write_data = '0;
        tick();
        chk(K_LED, 32'h0, "init_led");
        chk(K_DIGI, 32'h0, "init_digi");
        chk(K_IRQ, 32'h0, "init_irq");
        chk(K_TXD, 32'h1, "init_txd");
        rd(A_TH, 32'h0, "init_th");
        reset = 1'b0;

        // Reset in the middle of a UART frame with the timer running and irq pending
        wr(A_LED, 32'h5A);
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TCON, 32'h3);
        wr(A_TXD, 32'h55);
        tick();
        tick();
        chk(K_IRQ, 32'h1, "pre_rst_irq");
        chk(K_TXD, 32'h0, "pre_rst_txd");
        rd(A_CON, 32'h1, "pre_rst_busy");
        reset = 1'b1;
        bus.MemRead = 1'b1;
        bus.Address = A_TL;
        chk(K_TXD, 32'h1, "rst_txd");
        chk(K_IRQ, 32'h0, "rst_irq");
        chk(K_LED, 32'h0, "rst_led");
        chk(K_RD, 32'h0, "rst_tl");
        tick();
        rd(A_CON, 32'h0, "rst_busy");
        rd(A_TCON, 32'h0, "rst_tcon");
        reset = 1'b0;

        // Timer overflow and reload
        wr(A_TH, 32'hFFFF_FFFC);
        wr(A_TL, 32'hFFFF_FFFC);
        wr(A_TCON, 32'h3);
        rd(A_TL, 32'hFFFF_FFFC, "ovf_tl0");
        rd(A_TL, 32'hFFFF_FFFD, "ovf_tl1");
        rd(A_TL, 32'hFFFF_FFFE, "ovf_tl2");
        rd(A_TL, 32'hFFFF_FFFF, "ovf_tl3");
        chk(K_IRQ, 32'h1, "ovf_irq");
        rd(A_TL, 32'hFFFF_FFFC, "ovf_reload");
        rd(A_TCON, 32'h7, "ovf_tcon");
        wr(A_TCON, 32'h3);
        chk(K_IRQ, 32'h0, "irq_clear");
        rd(A_TCON, 32'h3, "tcon_clear");
        wr(A_TCON, 32'h0);

        // Collisions between CPU writes and the overflow cycle
        wr(A_TH, 32'h10);
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TCON, 32'h3);
        wr(A_TCON, 32'h3);
        chk(K_IRQ, 32'h1, "col_irq");
        rd(A_TCON, 32'h7, "col_tcon");
        wr(A_TCON, 32'h0);
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TCON, 32'h1);
        wr(A_TL, 32'h5);
        rd(A_TL, 32'h5, "col_tl_wr");
        rd(A_TCON, 32'h1, "col_noirq_tcon");
        wr(A_TCON, 32'h0);
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TCON, 32'h1);
        wr(A_TH, 32'h20);
        rd(A_TL, 32'h10, "col_old_th");
        wr(A_TCON, 32'h0);
        rd(A_TH, 32'h20, "col_new_th");

        // GPIO and 7-segment
        wr(A_LED, 32'h1A5);
        chk(K_LED, 32'hA5, "led_out");
        rd(A_LED, 32'hA5, "led_rd");
        switch = 8'h3C;
        rd(A_SW, 32'h3C, "sw_rd");
        wr(A_DIGI, 32'hFFF0F);
        chk(K_DIGI, 32'hF0F, "digi_out");
        rd(A_DIGI, 32'hF0F, "digi_rd");

        // Decode: unmapped, unaligned, write-only and no-strobe reads; ignored writes
        rd(32'h4000_0020, 32'h0, "rd_unmapped");
        rd(32'h4000_0002, 32'h0, "rd_unaligned");
        rd(A_TXD, 32'h0, "rd_txd");
        bus.Address = A_LED;
        chk(K_RD, 32'h0, "rd_no_strobe");
        tick();
        wr(A_SW, 32'hFFFF_FFFF);
        wr(32'h4000_0020, 32'hFFFF_FFFF);
        chk(K_LED, 32'hA5, "ign_led");
        chk(K_DIGI, 32'hF0F, "ign_digi");
        rd(A_TH, 32'h20, "ign_th");
        rd(A_TCON, 32'h0, "ign_tcon");

        // UART frame of 0xA5 with a write at cycle 10 that must be ignored
        frame = {1'b1, 8'hA5, 1'b0};
        wr(A_TXD, 32'hA5);
        for (int c = 0; c < 40; c++) begin
            if (c == 10) begin
                bus.MemRead    = 1'b0;
                bus.MemWrite   = 1'b1;
                bus.Address    = A_TXD;
                bus.Write_data = 32'h0;
            end else begin
                bus.MemRead    = 1'b1;
                bus.MemWrite   = 1'b0;
                bus.Address    = A_CON;
                bus.Write_data = 32'h0;
                chk(K_RD, 32'h1, $sformatf("uart_busy_c%0d", c));
            end
            chk(K_TXD, {31'd0, frame[c / 4]}, $sformatf("uart_txd_c%0d", c));
            tick();
        end
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        chk(K_TXD, 32'h1, "uart_idle_txd");
        rd(A_CON, 32'h0, "uart_idle_busy");

        tick();
        tick();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/peripheral_bus.md
Name: peripheral_bus

Overview:
Memory-mapped I/O block that sits beside the data memory on the single-cycle CPU's load/store path. It decodes the same address, write-data, read-strobe and write-strobe signals, for addresses in the 0x4000_0000 window. It contains a reloadable timer with an interrupt output, LED, switch and 7-segment registers, and a UART transmitter. Read data is combinational, so the CPU's write-back mux selects between data memory and this block by address.

Parameters:
BAUD_DIV, 5208, clock cycles per UART bit (50 MHz / 9600 baud).

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
MemRead  input  1  load strobe
MemWrite  input  1  store strobe
Address  input  32  byte address; full 32-bit compare; bits [1:0] must be 00
Write_data  input  32  store data
Read_data  output  32  load data, combinational
switch  input  8  board switches
led  output  8  LED register
digi  output  12  7-segment register (anode[11:8], segments[7:0])
irqout  output  1  timer interrupt request
uart_txd  output  1  serial transmit line, idles high

Behaviour:
- Register map (byte address: register, access):
  - 0x40000000: TH, 32-bit reload value, RW.
  - 0x40000004: TL, 32-bit counter, RW.
  - 0x40000008: TCON[2:0], RW. Bit0 = timer enable, bit1 = irq enable, bit2 = irq status.
  - 0x4000000C: led[7:0], RW.
  - 0x40000010: switch[7:0], RO.
  - 0x40000014: digi[11:0], RW.
  - 0x40000018: UART TXD[7:0], WO. A write starts a transmit; reads return 0.
  - 0x4000001C: UART CON[0] = tx_busy, RO.
- Reads:
  - Read_data is the zero-extended register value when MemRead=1 and Address matches exactly.
  - Otherwise Read_data is 0. This covers unmapped or unaligned addresses and MemRead=0.
- Writes:
  - A write takes effect on the rising edge when MemWrite=1 and Address matches.
  - Writes to RO registers and unmapped addresses are ignored.
  - Upper unused Write_data bits are dropped.
- Reset (asynchronous, immediate):
  - TH, TL and TCON = 0; led = 0; digi = 0; irqout = 0.
  - UART returns to IDLE: uart_txd = 1, tx_busy = 0, bit and baud counters = 0.
  - Reset during a UART frame aborts the frame.
- Timer, each cycle with TCON[0]=1:
  - If TL == 0xFFFFFFFF: TL <= TH, and if TCON[1]=1, TCON[2] <= 1 (overflow event).
  - Otherwise TL <= TL+1.
  - TCON[0]=0 freezes TL.
- irqout = TCON[1] & TCON[2], combinational from the registers.
- Timer write priority:
  - A CPU write to TL in the same cycle as a count or overflow wins; TL takes Write_data.
  - A CPU write to TCON stores Write_data[1:0]. The new TCON[2] = Write_data[2] OR the overflow event in that cycle, so an interrupt is never lost.
  - A CPU write to TH in the overflow cycle: the reload uses the old TH.
- UART transmit FSM (IDLE, START, DATA, STOP):
  - IDLE: uart_txd=1. A TXD write latches Write_data[7:0] into the shift register, sets tx_busy=1 and enters START on the next edge.
  - START: uart_txd=0 for BAUD_DIV cycles.
  - DATA: 8 bits, LSB first, each held BAUD_DIV cycles; a 3-bit index counts them.
  - STOP: uart_txd=1 for BAUD_DIV cycles, then IDLE with tx_busy=0.
  - uart_txd and tx_busy are registered. uart_txd falls on the edge that captures the write.
  - The full frame is 10*BAUD_DIV cycles.
  - A TXD write while tx_busy=1 is ignored; the shift register is unchanged.
  - The baud counter runs 0..BAUD_DIV-1 and wraps to 0 at each bit boundary.

Test Plan:
1. Reset mid-operation: start a UART frame and run TL counting, then assert reset for 3 cycles -> uart_txd=1, tx_busy=0, TL=0, irqout=0, led=0 immediately (before the next edge).
2. Timer overflow: write TH=0xFFFFFFFC, TL=0xFFFFFFFC, TCON=3 -> TL reads FD, FE, FF on successive cycles, then FC. TCON reads 7 and irqout=1. Write TCON=3 -> irqout=0 the next cycle.
3. Timer collision: with TL=0xFFFFFFFF and TCON=3, write TCON=3 in the overflow cycle -> TCON reads 7, irqout=1. Separately, write TL=5 in that cycle -> TL=5.
4. GPIO: write led=0x1A5 -> led=0xA5 and reads back 0x000000A5. Set switch=0x3C, read 0x40000010 -> 0x3C. Write digi=0xFFF0F -> digi=0xF0F.
5. UART with BAUD_DIV=4: write TXD=0xA5 -> uart_txd = 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles, and tx_busy=1 for 40 cycles. A second write of 0x00 at cycle 10 is ignored. CON reads 1 during the frame and 0 after.
6. Decode: read 0x40000020, 0x40000002, or any address with MemRead=0 -> 0. Write to 0x40000010 or 0x40000020 -> no register changes.
